ps2_key_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver for the picoVersat peripheral bus.
- Filters and synchronises PS2C/PS2D, deframes 11-bit PS/2 frames, and checks start, odd parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into one key event.
- Queues events in a first-word-fall-through FIFO that the CPU pops.
- Adds what a bare shift-register receiver lacks: glitch filter, inactivity timeout, prefix decoding, event buffering, and sticky error/overflow flags.

---
 rtl/ps2_key_fifo_pkg.sv | 22 ++
 rtl/ps2_key_fifo_if.sv | 23 ++
 rtl/ps2_key_fifo_sync.sv | 42 ++++
 rtl/ps2_key_fifo.sv | 174 +++++++++++++++++
 tb/tb_ps2_key_fifo.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_fifo_pkg.sv
// Shared constants for the PS/2 key FIFO: prefix bytes, frame FSM encodings,
// entry field positions and the frame parity helper.
package ps2_key_fifo_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int BRK_BIT = 9;
    localparam int EXT_BIT = 8;
    localparam int ENTRY_W = 10;

    // True when the 8 data bits plus the parity bit hold an odd number of ones
    function automatic logic odd_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_key_fifo_if.sv
// CPU-side bus of the PS/2 key FIFO: pop/clear controls, head entry and status.
interface ps2_key_fifo_if #(parameter int FIFO_AW = 3);

    logic               pop;
    logic               clr_err;
    logic               valid;
    logic [9:0]         data;
    logic [FIFO_AW:0]   count;
    logic               parity_err;
    logic               frame_err;
    logic               overflow;

    modport master (
        output pop, clr_err,
        input  valid, data, count, parity_err, frame_err, overflow
    );

    modport slave (
        input  pop, clr_err,
        output valid, data, count, parity_err, frame_err, overflow
    );

endinterface

// File: rtl/ps2_key_fifo_sync.sv
// PS/2 pin conditioning: two-flop synchronisers, PS2C majority-free glitch
// filter (all FILT_LEN samples must agree) and a one-cycle falling-edge strobe.
module ps2_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fe,
    output logic data_s
);

    logic [1:0]          c_sync;
    logic [1:0]          d_sync;
    logic [FILT_LEN-1:0] samples;
    logic                filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync  <= '1;
            d_sync  <= '1;
            samples <= '1;
            filt    <= 1'b1;
            fe      <= 1'b0;
        end else begin
            c_sync  <= {c_sync[0], ps2_clk};
            d_sync  <= {d_sync[0], ps2_data};
            samples <= {samples[FILT_LEN-2:0], c_sync[1]};
            fe      <= 1'b0;
            if (&samples) begin
                filt <= 1'b1;
            end else if (~|samples) begin
                filt <= 1'b0;
                fe   <= filt;
            end
        end
    end

    assign data_s = d_sync[1];

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: frame deframing with parity/stop checks and timeout,
// E0/F0 prefix folding, and a first-word-fall-through event FIFO.
module ps2_key_fifo
    import ps2_key_fifo_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_key_fifo_if.slave   bus
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    logic               fe, ds;
    logic [1:0]         state;
    logic [2:0]         bit_cnt;
    logic [7:0]         sh;
    logic               par;
    logic [TW-1:0]      tmo_cnt;
    logic               tmo;

    logic               done, done_ok, set_perr, set_ferr;
    logic [7:0]         done_byte;
    logic               ext_f, brk_f;
    logic               ev_push;
    logic [ENTRY_W-1:0] ev_data;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, do_pop, do_push;
    logic               perr_q, ferr_q, ovf_q;

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fe       (fe),
        .data_s   (ds)
    );

    assign tmo = (state != ST_IDLE) && !fe && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt <= '0;
        else if (state == ST_IDLE || fe) tmo_cnt <= '0;
        else tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Frame FSM; a finished or aborted frame yields a one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            par       <= 1'b0;
            done      <= 1'b0;
            done_ok   <= 1'b0;
            done_byte <= '0;
            set_perr  <= 1'b0;
            set_ferr  <= 1'b0;
        end else begin
            done     <= 1'b0;
            set_perr <= 1'b0;
            set_ferr <= 1'b0;
            if (tmo) begin
                state    <= ST_IDLE;
                done     <= 1'b1;
                done_ok  <= 1'b0;
                set_ferr <= 1'b1;
            end else if (fe) begin
                case (state)
                    ST_IDLE: if (!ds) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        sh      <= {ds, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= ds;
                        state <= ST_STOP;
                    end
                    default: begin
                        done      <= 1'b1;
                        done_ok   <= ds && odd_ok(sh, par);
                        done_byte <= sh;
                        set_perr  <= !odd_ok(sh, par);
                        set_ferr  <= !ds;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_f   <= 1'b0;
            brk_f   <= 1'b0;
            ev_push <= 1'b0;
            ev_data <= '0;
        end else begin
            ev_push <= 1'b0;
            if (done) begin
                if (!done_ok) begin
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                end else if (done_byte == PS2_EXT) begin
                    ext_f <= 1'b1;
                end else if (done_byte == PS2_BRK) begin
                    brk_f <= 1'b1;
                end else begin
                    ev_push          <= 1'b1;
                    ev_data[BRK_BIT] <= brk_f;
                    ev_data[EXT_BIT] <= ext_f;
                    ev_data[7:0]     <= done_byte;
                    ext_f            <= 1'b0;
                    brk_f            <= 1'b0;
                end
            end
        end
    end

    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = bus.pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = ev_push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= ev_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;

            if (set_perr)         perr_q <= 1'b1;
            else if (bus.clr_err) perr_q <= 1'b0;
            if (set_ferr)         ferr_q <= 1'b1;
            else if (bus.clr_err) ferr_q <= 1'b0;
            if (ev_push && full && !do_pop) ovf_q <= 1'b1;
            else if (bus.clr_err)           ovf_q <= 1'b0;
        end
    end

    assign bus.valid      = !empty;
    assign bus.data       = empty ? '0 : mem[rd_ptr];
    assign bus.count      = count;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Scoreboard bench for ps2_key_fifo: PS/2 frames are driven on the pins,
// expected events queued as sent and compared as the CPU side pops them.
module tb_ps2_key_fifo;
    import ps2_key_fifo_pkg::*;

    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 8;
    localparam int TMO     = 300;
    localparam int HALF    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    always #10 clk = ~clk;

    ps2_key_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();

    ps2_key_fifo #(.FILT_LEN(8), .FIFO_AW(FIFO_AW), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        logic [9:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s_underflow got=%h exp=<none>", name, bus.data);
            end else begin
                e = exp_q.pop_front();
                if (bus.valid !== 1'b1 || bus.data !== e) begin
                    failures++;
                    $display("FAIL %s_pop%0d got valid=%b data=%h exp valid=1 data=%h",
                             name, i, bus.valid, bus.data, e);
                end
            end
            bus.pop = 1'b1;
            @(negedge clk);
            bus.pop = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.valid !== 1'b0 || bus.data !== 10'h000 || bus.count !== 4'd0 ||
            bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h c=%0d p=%b f=%b o=%b exp all 0",
                     bus.valid, bus.data, bus.count, bus.parity_err, bus.frame_err, bus.overflow);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(10'h01D); send_frame(8'h1D, 1'b0, 11);
        exp_q.push_back(10'h04B); send_frame(8'h4B, 1'b0, 11);
        exp_q.push_back(10'h044); send_frame(8'h44, 1'b0, 11);
        settle();
        checks++;
        if (bus.count !== 4'd3) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=3", bus.count);
        end
        drain("basic", 3);
        checks++;
        if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags got p=%b f=%b o=%b v=%b exp 0 0 0 0",
                     bus.parity_err, bus.frame_err, bus.overflow, bus.valid);
        end
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 11);
        exp_q.push_back(10'h21D); send_frame(8'h1D, 1'b0, 11);
        settle();
        checks++;
        if (bus.count !== 4'd1) begin
            failures++;
            $display("FAIL break_count got=%0d exp=1", bus.count);
        end
        drain("break", 1);
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        exp_q.push_back(10'h375); send_frame(8'h75, 1'b0, 11);
        settle();
        checks++;
        if (bus.count !== 4'd1) begin
            failures++;
            $display("FAIL extbrk_count got=%0d exp=1", bus.count);
        end
        drain("extbrk", 1);
        exp_q.push_back(10'h075); send_frame(8'h75, 1'b0, 11);
        settle();
        drain("extbrk_plain", 1);
    endtask

    task automatic test_parity();
        send_frame(8'h7D, 1'b1, 11);
        settle();
        checks++;
        if (bus.count !== 4'd0 || bus.parity_err !== 1'b1) begin
            failures++;
            $display("FAIL parity_err got count=%0d perr=%b exp count=0 perr=1",
                     bus.count, bus.parity_err);
        end
        pulse_clr();
        checks++;
        if (bus.parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_clr got=%b exp=0", bus.parity_err);
        end
        exp_q.push_back(10'h01D); send_frame(8'h1D, 1'b0, 11);
        settle();
        drain("parity_after", 1);
    endtask

    task automatic test_timeout();
        send_frame(8'h44, 1'b0, 5);
        repeat (TMO + 10) @(negedge clk);
        checks++;
        if (bus.frame_err !== 1'b1 || dut.state !== ST_IDLE || bus.count !== 4'd0) begin
            failures++;
            $display("FAIL timeout got ferr=%b state=%0d count=%0d exp ferr=1 state=0 count=0",
                     bus.frame_err, dut.state, bus.count);
        end
        pulse_clr();
        exp_q.push_back(10'h044); send_frame(8'h44, 1'b0, 11);
        settle();
        drain("timeout_after", 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(10'h01D);
            send_frame(8'h1D, 1'b0, 11);
        end
        settle();
        checks++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill got count=%0d ovf=%b exp count=8 ovf=0", bus.count, bus.overflow);
        end
        send_frame(8'h4B, 1'b0, 11);
        settle();
        checks++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow got count=%0d ovf=%b exp count=8 ovf=1", bus.count, bus.overflow);
        end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        fork
            send_frame(8'h4B, 1'b0, 11);
            begin
                int n;
                logic [9:0] e;
                n = 0;
                @(negedge clk);
                while (dut.ev_push !== 1'b1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n >= 2000) begin
                    failures++;
                    $display("FAIL b2b_push_wait got=timeout exp=push");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data !== e) begin
                        failures++;
                        $display("FAIL b2b_head got=%h exp=%h", bus.data, e);
                    end
                    bus.pop = 1'b1;
                    exp_q.push_back(10'h04B);
                    @(negedge clk);
                    bus.pop = 1'b0;
                end
            end
        join
        settle();
        checks++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count got count=%0d ovf=%b exp count=8 ovf=0", bus.count, bus.overflow);
        end
        drain("b2b", DEPTH);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        #30;
        ps2_clk  = 1'b1;
        repeat (30) @(negedge clk);
        ps2_data = 1'b1;
        checks++;
        if (dut.state !== ST_IDLE || bus.count !== 4'd0) begin
            failures++;
            $display("FAIL glitch got state=%0d count=%0d exp state=0 count=0", dut.state, bus.count);
        end
    endtask

    task automatic test_reset_midframe();
        exp_q.push_back(10'h01D); send_frame(8'h1D, 1'b0, 11);
        settle();
        send_frame(8'h4B, 1'b0, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.data !== 10'h000 || bus.count !== 4'd0 ||
            bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL midreset got v=%b d=%h c=%0d p=%b f=%b o=%b exp all 0",
                     bus.valid, bus.data, bus.count, bus.parity_err, bus.frame_err, bus.overflow);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back(10'h04B); send_frame(8'h4B, 1'b0, 11);
        settle();
        checks++;
        if (bus.count !== 4'd1) begin
            failures++;
            $display("FAIL midreset_after_count got=%0d exp=1", bus.count);
        end
        drain("midreset_after", 1);
    endtask

    initial begin
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        repeat (5) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        test_basic();
        test_break();
        test_ext_break();
        test_parity();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1);
    end

endmodule
